bkm_e_accumulator: RTL

//  Iterative E-mode BKM accumulator; stage directly downstream of multiply_by_d.
//  - Holds complex E = e_x + i*e_y and drives it to multiply_by_d x_in/y_in.
//  - Takes back prod = d*E and adds (prod >>> n) into E on each iteration n = 0..ITER-1.
//  - Forwards digits d_x/d_y from the upstream digit selector; iter_n tells the selector the current step.

---
 rtl/bkm_e_accumulator.sv | 128 ++++++++++++
 1 files changed

// File: rtl/bkm_e_accumulator.sv
// bkm_e_accumulator: iterative E-mode BKM accumulator.
// Holds E = e_x + i*e_y, feeds it to multiply_by_d and folds (d*E >>> n)
// back into E for n = 0..ITER-1. Illegal digits (2'b10) are forced to 0
// and latched in a sticky dig_err flag.
// Optional macro BKM_ACC_SAT_EN: saturating adds instead of wrapping adds.
module bkm_e_accumulator #(
    parameter int W    = 4,
    parameter int ITER = 4,
    parameter int NW   = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  init_x,
    input  logic [W-1:0]  init_y,
    input  logic [1:0]    dig_x,
    input  logic [1:0]    dig_y,
    input  logic [W-1:0]  prod_x,
    input  logic [W-1:0]  prod_y,
    output logic [1:0]    d_x,
    output logic [1:0]    d_y,
    output logic [W-1:0]  e_x,
    output logic [W-1:0]  e_y,
    output logic [NW-1:0] iter_n,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          dig_err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [NW-1:0] LAST = NW'(ITER - 1);

    state_t          state, state_n;
    logic [W-1:0]    e_x_n, e_y_n;
    logic [NW-1:0]   iter_n_n;
    logic            dig_err_n;
    logic signed [W-1:0] sh_x, sh_y;
    logic [W-1:0]    add_x, add_y;
    logic            bad_x, bad_y;

    // Signed W-bit add; wraps by default, clamps when saturation is enabled.
    function automatic logic [W-1:0] acc_add(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BKM_ACC_SAT_EN
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        return s[W-1:0];
`else
        return a + b;
`endif
    endfunction

    assign bad_x = (dig_x == 2'b10);
    assign bad_y = (dig_y == 2'b10);
    assign d_x   = bad_x ? 2'b00 : dig_x;
    assign d_y   = bad_y ? 2'b00 : dig_y;

    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    // Shifted product and the per-axis accumulate for the current step.
    always_comb begin
        sh_x  = $signed(prod_x) >>> iter_n;
        sh_y  = $signed(prod_y) >>> iter_n;
        add_x = acc_add(e_x, sh_x);
        add_y = acc_add(e_y, sh_y);
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_n   = state;
        e_x_n     = e_x;
        e_y_n     = e_y;
        iter_n_n  = iter_n;
        dig_err_n = dig_err;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = RUN;
                    e_x_n     = init_x;
                    e_y_n     = init_y;
                    iter_n_n  = '0;
                    dig_err_n = 1'b0;
                end
            end
            RUN: begin
                e_x_n = add_x;
                e_y_n = add_y;
                if (bad_x || bad_y)
                    dig_err_n = 1'b1;
                if (iter_n == LAST)
                    state_n = DONE;
                else
                    iter_n_n = iter_n + 1'b1;
            end
            DONE: begin
                if (out_ready)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            e_x     <= '0;
            e_y     <= '0;
            iter_n  <= '0;
            dig_err <= 1'b0;
        end else begin
            state   <= state_n;
            e_x     <= e_x_n;
            e_y     <= e_y_n;
            iter_n  <= iter_n_n;
            dig_err <= dig_err_n;
        end
    end

endmodule
